// File: rtl/serial_pattern_tx_if.sv
// Handshake/payload bundle between a pattern requester and serial_pattern_tx.
// The master drives the frame request; the slave returns the serial stream and status.
interface serial_pattern_tx_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNTW  = 4
);
  logic             start;
  logic [WIDTH-1:0] pattern;
  logic [CNTW-1:0]  len;
  logic [CNTW-1:0]  reps;
  logic [CNTW-1:0]  gap;
  logic             out;
  logic             valid;
  logic             busy;
  logic             done;

  modport master (
    output start, pattern, len, reps, gap,
    input  out, valid, busy, done
  );

  modport slave (
    input  start, pattern, len, reps, gap,
    output out, valid, busy, done
  );
endinterface

// File: rtl/serial_pattern_tx.sv
// Serial pattern generator: shifts pattern[len-1:0] out MSB-first on a registered bit,
// with optional frame repetition and idle gaps between repetitions.
module serial_pattern_tx #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNTW  = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  serial_pattern_tx_if.slave   s
);

  localparam int unsigned LENW = $clog2(WIDTH + 1);
  localparam int unsigned LW   = (LENW > CNTW) ? LENW : CNTW;

  typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_pat, w_pat_nxt;
  logic [LW-1:0]    r_len, w_len_nxt;
  logic [LW-1:0]    r_bit_cnt, w_bit_cnt_nxt;
  logic [CNTW-1:0]  r_rep_cnt, w_rep_cnt_nxt;
  logic [CNTW-1:0]  r_gap, w_gap_nxt;
  logic [CNTW-1:0]  r_gap_cnt, w_gap_cnt_nxt;
  logic             r_out, w_out_nxt;
  logic             r_valid, w_valid_nxt;
  logic             r_busy, w_busy_nxt;
  logic             r_done, w_done_nxt;
  logic [LW-1:0]    w_len_clamp;
  logic [CNTW-1:0]  w_reps_eff;

  // Out-of-range lengths collapse to a full-width frame; zero reps means one frame.
  always_comb begin
    w_len_clamp = LW'(s.len);
    if (s.len == '0 || 32'(s.len) > WIDTH) w_len_clamp = LW'(WIDTH);
    w_reps_eff = (s.reps == '0) ? CNTW'(1) : s.reps;
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_pat_nxt     = r_pat;
    w_len_nxt     = r_len;
    w_bit_cnt_nxt = r_bit_cnt;
    w_rep_cnt_nxt = r_rep_cnt;
    w_gap_nxt     = r_gap;
    w_gap_cnt_nxt = r_gap_cnt;
    w_out_nxt     = 1'b0;
    w_valid_nxt   = 1'b0;
    w_busy_nxt    = 1'b0;
    w_done_nxt    = 1'b0;

    unique case (r_state)
      IDLE: begin
        if (s.start) begin
          w_state_nxt   = SEND;
          w_pat_nxt     = s.pattern;
          w_len_nxt     = w_len_clamp;
          w_bit_cnt_nxt = w_len_clamp;
          w_rep_cnt_nxt = w_reps_eff;
          w_gap_nxt     = s.gap;
          w_out_nxt     = 1'(s.pattern >> LW'(w_len_clamp - LW'(1)));
          w_valid_nxt   = 1'b1;
          w_busy_nxt    = 1'b1;
        end
      end
      // r_bit_cnt is the number of bits left including the one now on the line.
      SEND: begin
        if (r_bit_cnt > LW'(1)) begin
          w_bit_cnt_nxt = LW'(r_bit_cnt - LW'(1));
          w_out_nxt     = 1'(r_pat >> LW'(r_bit_cnt - LW'(2)));
          w_valid_nxt   = 1'b1;
          w_busy_nxt    = 1'b1;
        end else if (r_rep_cnt > CNTW'(1)) begin
          w_rep_cnt_nxt = CNTW'(r_rep_cnt - CNTW'(1));
          w_busy_nxt    = 1'b1;
          if (r_gap != '0) begin
            w_state_nxt   = GAP;
            w_gap_cnt_nxt = r_gap;
          end else begin
            w_bit_cnt_nxt = r_len;
            w_out_nxt     = 1'(r_pat >> LW'(r_len - LW'(1)));
            w_valid_nxt   = 1'b1;
          end
        end else begin
          w_state_nxt = DONE;
          w_done_nxt  = 1'b1;
        end
      end
      GAP: begin
        w_busy_nxt = 1'b1;
        if (r_gap_cnt > CNTW'(1)) begin
          w_gap_cnt_nxt = CNTW'(r_gap_cnt - CNTW'(1));
        end else begin
          w_state_nxt   = SEND;
          w_bit_cnt_nxt = r_len;
          w_out_nxt     = 1'(r_pat >> LW'(r_len - LW'(1)));
          w_valid_nxt   = 1'b1;
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_pat     <= '0;
      r_len     <= '0;
      r_bit_cnt <= '0;
      r_rep_cnt <= '0;
      r_gap     <= '0;
      r_gap_cnt <= '0;
      r_out     <= 1'b0;
      r_valid   <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_pat     <= w_pat_nxt;
      r_len     <= w_len_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_rep_cnt <= w_rep_cnt_nxt;
      r_gap     <= w_gap_nxt;
      r_gap_cnt <= w_gap_cnt_nxt;
      r_out     <= w_out_nxt;
      r_valid   <= w_valid_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
    end
  end

  assign s.out   = r_out;
  assign s.valid = r_valid;
  assign s.busy  = r_busy;
  assign s.done  = r_done;

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Directed bench for serial_pattern_tx: each scenario compares {out,valid,busy,done}
// cycle by cycle against hand-computed vectors (leftmost vector bit = cycle T+1).
module tb_serial_pattern_tx;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  serial_pattern_tx_if #(.WIDTH(8), .CNTW(4)) bus ();

  serial_pattern_tx #(.WIDTH(8), .CNTW(4)) dut (
    .clk   (clk),
    .reset (reset),
    .s     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Request a frame; the start is sampled at the following rising edge (edge T).
  task automatic kick(input logic [7:0] p, input logic [3:0] l, input logic [3:0] r,
                      input logic [3:0] g);
    @(negedge clk);
    bus.pattern = p;
    bus.len     = l;
    bus.reps    = r;
    bus.gap     = g;
    bus.start   = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  task automatic test_reset();
    logic [3:0] got;
    reset     = 1'b1;
    bus.start = 1'b1;
    bus.pattern = 8'hFF;
    bus.len   = 4'd4;
    bus.reps  = 4'd1;
    bus.gap   = 4'd0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      got = {bus.out, bus.valid, bus.busy, bus.done};
      checks++;
      if (got !== 4'b0000) begin
        errors++;
        $display("FAIL reset cycle %0d: got %b expected 0000", k, got);
      end
      if (k == 2) begin
        reset     = 1'b0;
        bus.start = 1'b0;
      end
    end
  endtask

  task automatic test_single_frame();
    logic [15:0] eo, ev, eb, ed;
    logic [3:0]  got, exp;
    int          n;
    n = 5; eo = 16'b10110; ev = 16'b11110; eb = 16'b11110; ed = 16'b00001;
    kick(8'h0B, 4'd4, 4'd1, 4'd0);
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      got = {bus.out, bus.valid, bus.busy, bus.done};
      exp = {eo[n-k], ev[n-k], eb[n-k], ed[n-k]};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL single T+%0d: got %b expected %b", k, got, exp);
      end
    end
  endtask

  task automatic test_repeat_gap();
    logic [15:0] eo, ev, eb, ed;
    logic [3:0]  got, exp;
    int          n;
    n  = 14;
    eo = 16'b10100101001010;
    ev = 16'b11100111001110;
    eb = 16'b11111111111110;
    ed = 16'b00000000000001;
    kick(8'h05, 4'd3, 4'd3, 4'd2);
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      got = {bus.out, bus.valid, bus.busy, bus.done};
      exp = {eo[n-k], ev[n-k], eb[n-k], ed[n-k]};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL repeat_gap T+%0d: got %b expected %b", k, got, exp);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] eo, ev, eb, ed;
    logic [3:0]  got, exp;
    int          n;
    n = 7; eo = 16'b1011010; ev = 16'b1111110; eb = 16'b1111110; ed = 16'b0000001;
    kick(8'h05, 4'd3, 4'd2, 4'd0);
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      got = {bus.out, bus.valid, bus.busy, bus.done};
      exp = {eo[n-k], ev[n-k], eb[n-k], ed[n-k]};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL back_to_back T+%0d: got %b expected %b", k, got, exp);
      end
    end
  endtask

  task automatic test_clamp();
    logic [15:0] eo, ev, eb, ed;
    logic [3:0]  got, exp;
    logic [3:0]  lens [2];
    int          n;
    n = 9; eo = 16'b101001010; ev = 16'b111111110; eb = 16'b111111110; ed = 16'b000000001;
    lens[0] = 4'd0;
    lens[1] = 4'd12;
    for (int t = 0; t < 2; t++) begin
      kick(8'hA5, lens[t], 4'd0, 4'd0);
      for (int k = 1; k <= n; k++) begin
        @(negedge clk);
        got = {bus.out, bus.valid, bus.busy, bus.done};
        exp = {eo[n-k], ev[n-k], eb[n-k], ed[n-k]};
        checks++;
        if (got !== exp) begin
          errors++;
          $display("FAIL clamp len=%0d T+%0d: got %b expected %b", lens[t], k, got, exp);
        end
      end
    end
  endtask

  task automatic test_ignored_start();
    logic [15:0] eo, ev, eb, ed;
    logic [3:0]  got, exp;
    int          n;
    n = 9; eo = 16'b101100000; ev = 16'b111100000; eb = 16'b111100000; ed = 16'b000010000;
    kick(8'h0B, 4'd4, 4'd1, 4'd0);
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      got = {bus.out, bus.valid, bus.busy, bus.done};
      exp = {eo[n-k], ev[n-k], eb[n-k], ed[n-k]};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL ignored_start T+%0d: got %b expected %b", k, got, exp);
      end
      if (k == 2) begin
        bus.start   = 1'b1;
        bus.pattern = 8'hF0;
        bus.len     = 4'd2;
        bus.reps    = 4'd3;
      end
      if (k == 3) bus.start = 1'b0;
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [15:0] eo, ev, eb, ed;
    logic [3:0]  got, exp;
    int          n;
    n = 4; eo = 16'b1000; ev = 16'b1100; eb = 16'b1100; ed = 16'b0000;
    kick(8'hA5, 4'd8, 4'd1, 4'd0);
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      got = {bus.out, bus.valid, bus.busy, bus.done};
      exp = {eo[n-k], ev[n-k], eb[n-k], ed[n-k]};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL reset_mid T+%0d: got %b expected %b", k, got, exp);
      end
      if (k == 2) reset = 1'b1;
      if (k == 3) reset = 1'b0;
    end
    n = 9; eo = 16'b101001010; ev = 16'b111111110; eb = 16'b111111110; ed = 16'b000000001;
    kick(8'hA5, 4'd8, 4'd1, 4'd0);
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      got = {bus.out, bus.valid, bus.busy, bus.done};
      exp = {eo[n-k], ev[n-k], eb[n-k], ed[n-k]};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL reset_restart T+%0d: got %b expected %b", k, got, exp);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_single_frame();
    test_repeat_gap();
    test_back_to_back();
    test_clamp();
    test_ignored_start();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
